// File: rtl/reg_file_server_pkg.sv
// Shared constants and port FSM encoding for the decode-stage register file server.
package reg_file_server_pkg;

  localparam int WIDTH        = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int NUM_REGS     = 2 ** REG_ADDR_LEN;

  localparam logic [REG_ADDR_LEN-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RESP = 2'b01,
    HOLD = 2'b10
  } port_state_t;

endpackage

// File: rtl/reg_file_server_read_port.sv
// One read-port responder: latches a request, returns data with write bypass,
// pulses st once per answer and refreshes held data when writeback hits it.
module reg_read_port
  import reg_file_server_pkg::*;
#(
  parameter int WIDTH        = reg_file_server_pkg::WIDTH,
  parameter int REG_ADDR_LEN = reg_file_server_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    en,
  input  logic [REG_ADDR_LEN-1:0] addr,
  input  logic [WIDTH-1:0]        arr_data,
  input  logic                    wr_en,
  input  logic [REG_ADDR_LEN-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        data,
  output logic                    st
);

  port_state_t             state, state_next;
  logic [REG_ADDR_LEN-1:0] lat_addr, lat_addr_next;
  logic [WIDTH-1:0]        data_next;
  logic                    st_next;
  logic                    addr_bypass;
  logic                    lat_hit;
  logic [WIDTH-1:0]        capture;

  // A same-cycle write to the requested register must win over the stale array value.
  assign addr_bypass = wr_en && (wr_addr == addr) && (addr != ZERO_REG);
  assign lat_hit     = wr_en && (wr_addr == lat_addr) && (lat_addr != ZERO_REG);
  assign capture     = addr_bypass ? wr_data : arr_data;

  always_comb begin
    state_next    = state;
    lat_addr_next = lat_addr;
    data_next     = data;
    st_next       = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_next    = RESP;
            lat_addr_next = addr;
            data_next     = capture;
            st_next       = 1'b1;
          end
        end
        RESP: state_next = HOLD;
        HOLD: begin
          if (!en) begin
            state_next = IDLE;
          end else if (addr != lat_addr) begin
            state_next    = RESP;
            lat_addr_next = addr;
            data_next     = capture;
            st_next       = 1'b1;
          end else if (lat_hit) begin
            state_next = RESP;
            data_next  = wr_data;
            st_next    = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // st is registered alongside the entry into RESP so it is high exactly while in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_addr <= '0;
      data     <= '0;
      st       <= 1'b0;
    end else begin
      state    <= state_next;
      lat_addr <= lat_addr_next;
      data     <= data_next;
      st       <= st_next;
    end
  end

endmodule

// File: rtl/reg_file_server.sv
// 32x32 general register file with one writeback port and two handshaked read ports.
module reg_file_server
  import reg_file_server_pkg::*;
#(
  parameter int WIDTH        = reg_file_server_pkg::WIDTH,
  parameter int REG_ADDR_LEN = reg_file_server_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] rd1_addr,
  input  logic                    rd1_en,
  output logic [WIDTH-1:0]        rd1_data,
  output logic                    rd1_st,
  input  logic [REG_ADDR_LEN-1:0] rd2_addr,
  input  logic                    rd2_en,
  output logic [WIDTH-1:0]        rd2_data,
  output logic                    rd2_st,
  input  logic [REG_ADDR_LEN-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_en,
  input  logic                    flush
);

  localparam int NUM_REGS = 2 ** REG_ADDR_LEN;

  logic [WIDTH-1:0] regs [NUM_REGS];

  // Register 0 is never written, so it reads as zero after reset without a read-side mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_REG)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(.WIDTH(WIDTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_port1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .en       (rd1_en),
    .addr     (rd1_addr),
    .arr_data (regs[rd1_addr]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (rd1_data),
    .st       (rd1_st)
  );

  reg_read_port #(.WIDTH(WIDTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_port2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .en       (rd2_en),
    .addr     (rd2_addr),
    .arr_data (regs[rd2_addr]),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (rd2_data),
    .st       (rd2_st)
  );

endmodule

// File: tb/tb_reg_file_server.sv
// Directed self-checking bench for reg_file_server: handshake latency, bypass,
// HOLD refresh, address change, flush and mid-request reset.
module tb_reg_file_server;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd1_addr, rd2_addr, wr_addr;
  logic        rd1_en, rd2_en, wr_en, flush;
  logic [31:0] rd1_data, rd2_data, wr_data;
  logic        rd1_st, rd2_st;

  int tests_run = 0;
  int tests_failed = 0;

  reg_file_server dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_addr (rd1_addr),
    .rd1_en   (rd1_en),
    .rd1_data (rd1_data),
    .rd1_st   (rd1_st),
    .rd2_addr (rd2_addr),
    .rd2_en   (rd2_en),
    .rd2_data (rd2_data),
    .rd2_st   (rd2_st),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyWrite(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd1_addr = '0; rd2_addr = '0; wr_addr = '0; wr_data = '0;
    rd1_en = 1'b0; rd2_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("reset_rd1_st", {31'b0, rd1_st}, 32'h0);
    checkOutput("reset_rd1_data", rd1_data, 32'h0);
    checkOutput("reset_rd2_st", {31'b0, rd2_st}, 32'h0);
    checkOutput("reset_rd2_data", rd2_data, 32'h0);

    // Read of a freshly reset register, then a write and re-read.
    rd1_addr = 5'd3; rd1_en = 1'b1;
    tick();
    checkOutput("rd3_first_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("rd3_first_data", rd1_data, 32'h0);
    rd1_en = 1'b0;
    tick();
    checkOutput("rd3_first_st_drop", {31'b0, rd1_st}, 32'h0);
    tick();
    applyWrite(5'd3, 32'hDEADBEEF);
    rd1_en = 1'b1;
    tick();
    checkOutput("rd3_second_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("rd3_second_data", rd1_data, 32'hDEADBEEF);
    rd1_en = 1'b0;
    tick();
    checkOutput("rd3_second_single_pulse", {31'b0, rd1_st}, 32'h0);
    checkOutput("rd3_second_data_held", rd1_data, 32'hDEADBEEF);
    tick();

    // Writes to register 0 are dropped; both ports read it together.
    applyWrite(5'd0, 32'hFFFFFFFF);
    rd1_addr = 5'd0; rd2_addr = 5'd0; rd1_en = 1'b1; rd2_en = 1'b1;
    tick();
    checkOutput("r0_rd1_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("r0_rd2_st", {31'b0, rd2_st}, 32'h1);
    checkOutput("r0_rd1_data", rd1_data, 32'h0);
    checkOutput("r0_rd2_data", rd2_data, 32'h0);
    rd1_en = 1'b0; rd2_en = 1'b0;
    tick();
    tick();

    // Same-cycle write bypass on port 2.
    applyWrite(5'd7, 32'h1);
    rd2_addr = 5'd7; rd2_en = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    checkOutput("bypass_rd2_st", {31'b0, rd2_st}, 32'h1);
    checkOutput("bypass_rd2_data", rd2_data, 32'h12345678);
    rd2_en = 1'b0;
    tick();
    tick();

    // HOLD refresh on a write hitting the latched address; unrelated write is ignored.
    applyWrite(5'd5, 32'hA);
    applyWrite(5'd9, 32'h99);
    rd1_addr = 5'd5; rd1_en = 1'b1;
    tick();
    checkOutput("hold_first_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("hold_first_data", rd1_data, 32'hA);
    tick();
    checkOutput("hold_idle_st", {31'b0, rd1_st}, 32'h0);
    applyWrite(5'd5, 32'hB);
    checkOutput("hold_refresh_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("hold_refresh_data", rd1_data, 32'hB);
    tick();
    checkOutput("hold_refresh_st_drop", {31'b0, rd1_st}, 32'h0);
    applyWrite(5'd6, 32'h66);
    checkOutput("hold_other_write_st", {31'b0, rd1_st}, 32'h0);
    checkOutput("hold_other_write_data", rd1_data, 32'hB);

    // Address change while en held starts a new answer.
    rd1_addr = 5'd9;
    tick();
    checkOutput("addr_change_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("addr_change_data", rd1_data, 32'h99);
    rd1_en = 1'b0;
    tick();
    tick();

    // Independent concurrent reads.
    applyWrite(5'd2, 32'h22);
    applyWrite(5'd4, 32'h44);
    rd1_addr = 5'd2; rd2_addr = 5'd4; rd1_en = 1'b1; rd2_en = 1'b1;
    tick();
    checkOutput("dual_rd1_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("dual_rd1_data", rd1_data, 32'h22);
    checkOutput("dual_rd2_st", {31'b0, rd2_st}, 32'h1);
    checkOutput("dual_rd2_data", rd2_data, 32'h44);
    rd1_en = 1'b0; rd2_en = 1'b0;
    tick();
    tick();

    // Flush wins over a new request; data keeps its last value.
    rd1_addr = 5'd4; rd1_en = 1'b1; flush = 1'b1;
    tick();
    checkOutput("flush_st", {31'b0, rd1_st}, 32'h0);
    checkOutput("flush_data_kept", rd1_data, 32'h22);
    flush = 1'b0; rd1_en = 1'b0;
    tick();
    checkOutput("flush_no_late_st", {31'b0, rd1_st}, 32'h0);
    rd1_en = 1'b1;
    tick();
    checkOutput("post_flush_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("post_flush_data", rd1_data, 32'h44);

    // Reset while in RESP clears outputs and the array.
    rst_n = 1'b0; rd1_en = 1'b0;
    tick();
    checkOutput("midreset_rd1_st", {31'b0, rd1_st}, 32'h0);
    checkOutput("midreset_rd1_data", rd1_data, 32'h0);
    checkOutput("midreset_rd2_data", rd2_data, 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("midreset_no_pulse", {31'b0, rd1_st}, 32'h0);
    rd1_addr = 5'd3; rd2_addr = 5'd5; rd1_en = 1'b1; rd2_en = 1'b1;
    tick();
    checkOutput("cleared_r3_st", {31'b0, rd1_st}, 32'h1);
    checkOutput("cleared_r3_data", rd1_data, 32'h0);
    checkOutput("cleared_r5_data", rd2_data, 32'h0);
    rd1_en = 1'b0; rd2_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_server.md
Name: reg_file_server

Overview:
- Responder side of the decode-stage register-read handshake: two independent read ports answer addr/en requests with data plus a status strobe (st).
- One write port is driven from writeback.
- 32 x 32-bit general register array; register 0 is hardwired to zero.
- Sits beside the decode stage. Decode raises en, waits for an st pulse, then samples data.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- REG_ADDR_LEN, 5, register address width.
- NUM_REGS, 32, number of registers (2**REG_ADDR_LEN).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rd1_addr  input  REG_ADDR_LEN  read port 1 register address
- rd1_en  input  1  read port 1 request; held high until serviced
- rd1_data  output  WIDTH  read port 1 returned data
- rd1_st  output  1  read port 1 status strobe; one-cycle pulse when rd1_data valid
- rd2_addr  input  REG_ADDR_LEN  read port 2 register address
- rd2_en  input  1  read port 2 request
- rd2_data  output  WIDTH  read port 2 returned data
- rd2_st  output  1  read port 2 status strobe
- wr_addr  input  REG_ADDR_LEN  write address
- wr_data  input  WIDTH  write data
- wr_en  input  1  write enable
- flush  input  1  abort all in-flight read requests

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All registers cleared to 0.
  - rdN_data=0, rdN_st=0.
  - Both port FSMs go to IDLE.
  - Writes and requests in the same cycle are ignored.
- Write:
  - At a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Writes to address 0 are dropped; reads of address 0 always return 0.
- Per-port FSM, each port independent, states IDLE, RESP, HOLD:
  - IDLE: if en=1, latch addr into lat_addr and go to RESP. Data is captured with write bypass: if wr_en=1, wr_addr==addr and addr!=0, capture wr_data; otherwise capture reg[addr].
  - RESP: st=1 for exactly this cycle; data valid. Next state is HOLD.
  - HOLD: st=0; data held stable.
    - en=0: go to IDLE.
    - en=1 and addr!=lat_addr: treat as a new request. Recapture with bypass, go to RESP, and pulse st in the following cycle.
    - en=1, same address, and a write hits lat_addr (wr_en=1, wr_addr==lat_addr, lat_addr!=0): update data to wr_data next cycle and go to RESP, pulsing st again.
- Latency: en sampled high in IDLE gives data and st=1 on the next cycle, i.e. 1-cycle latency.
- Back-to-back requests: en may drop and rise again in consecutive cycles. Minimum request spacing is 3 cycles (IDLE->RESP->HOLD->IDLE).
- flush=1: both FSMs go to IDLE next cycle and st is forced to 0 that cycle. rdN_data retains its last value. Flush wins over a new request in the same cycle.
- Both ports reading the same address is legal, and both return identical data in the same cycle.
- Both ports and a write may all be active in one cycle; bypass applies to each port independently.
- Data outputs are registered; st outputs are registered. No combinational path from inputs to outputs.
- Reset mid-request: FSMs go to IDLE and no st pulse is emitted. The requester must re-raise en.

Decomposition:
- Shared package/include (alongside Parameters.v) holds:
  - WIDTH and REG_ADDR_LEN constants.
  - Port FSM state encoding: IDLE=2'b00, RESP=2'b01, HOLD=2'b10.
  - ZERO_REG=0.
- One sub-module, reg_read_port, is instantiated twice.
  - It contains the FSM, lat_addr, the bypass mux and the data/st registers.
  - Inputs: array read value, write-snoop signals and flush.
- The top level owns the register array and the write logic.

Test Plan:
- Reset then write-read: after reset, rd1_addr=3, rd1_en=1 -> rd1_st=1 one cycle later, rd1_data=0. Then wr_en=1, wr_addr=3, wr_data=32'hDEADBEEF; a new request to 3 -> rd1_data=32'hDEADBEEF with a single-cycle st pulse.
- Register 0: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF; then read 0 on both ports -> both return 0 with st on the same cycle.
- Bypass: same cycle rd2_en=1, rd2_addr=7, wr_en=1, wr_addr=7, wr_data=32'h12345678 (reg7 previously 32'h1) -> rd2_data=32'h12345678 next cycle.
- HOLD refresh: port 1 in HOLD on addr 5 (data 32'hA), en held; write 32'hB to 5 -> second st pulse with rd1_data=32'hB. A write to 6 instead -> no pulse.
- Address change in HOLD: en held, rd1_addr changes 5->9 -> st pulses one cycle later with reg9. Dual-port concurrency: port 1 addr 2 and port 2 addr 4 -> independent, correct values.
- Flush/reset mid-request: rd1_en rises with flush=1 in the same cycle -> no st pulse; FSM stays IDLE. rst_n=0 during RESP -> st=0 the next cycle and all data outputs cleared to 0.
